// File: rtl/sevseg_scan_ctrl_if.sv
// Load channel into the seven-segment scan controller: packed nibbles plus leading-zero flag.
// Single valid/ready transfer; the master must hold data stable while ready is low.
interface sevseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic                      blank_lz;

    modport master (
        output load_valid,
        output load_data,
        output blank_lz,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  blank_lz,
        output load_ready
    );
endinterface

// File: rtl/sevseg_scan_ctrl.sv
// Time-multiplexed hex display scanner; loads land on frame boundaries, outputs registered.
// load_ready falls while a load is pending and rises again at the next frame end.
module sevseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 50000,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    sevseg_scan_ctrl_if.slave     load,
    output logic [3:0]            nibble,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int DW  = 4 * NUM_DIGITS;
    localparam int IW  = $clog2(NUM_DIGITS);
    localparam int DCW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int CW  = (DCW > GCW) ? DCW : GCW;

    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {GAP, SCAN} state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [DW-1:0]         pend_dat, pend_dat_nxt;
    logic                  pend_lz, pend_lz_nxt;
    logic                  pend_full, pend_full_nxt;
    logic [DW-1:0]         disp_dat, disp_dat_nxt;
    logic                  disp_lz, disp_lz_nxt;
    logic                  frame_end;
    logic                  lz_run;
    logic [NUM_DIGITS-1:0] zero_above;
    logic                  suppress;
    logic [3:0]            nibble_nxt;
    logic [NUM_DIGITS-1:0] digit_sel_nxt;
    logic                  blank_nxt;

    assign load.load_ready = ~pend_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= GAP;
            idx        <= '0;
            cnt        <= '0;
            pend_dat   <= '0;
            pend_lz    <= 1'b0;
            pend_full  <= 1'b0;
            disp_dat   <= '0;
            disp_lz    <= 1'b0;
            nibble     <= 4'h0;
            digit_sel  <= '1;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            pend_dat   <= pend_dat_nxt;
            pend_lz    <= pend_lz_nxt;
            pend_full  <= pend_full_nxt;
            disp_dat   <= disp_dat_nxt;
            disp_lz    <= disp_lz_nxt;
            nibble     <= nibble_nxt;
            digit_sel  <= digit_sel_nxt;
            blank      <= blank_nxt;
            frame_done <= frame_end;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt + CW'(1);
        frame_end     = 1'b0;
        pend_dat_nxt  = pend_dat;
        pend_lz_nxt   = pend_lz;
        pend_full_nxt = pend_full;
        disp_dat_nxt  = disp_dat;
        disp_lz_nxt   = disp_lz;
        lz_run        = 1'b1;
        zero_above    = '0;
        suppress      = 1'b0;
        nibble_nxt    = 4'h0;
        digit_sel_nxt = '1;
        blank_nxt     = 1'b1;

        case (state)
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                end
            end
            SCAN: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            default: begin
                state_nxt = GAP;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase

        // Promotion needs pend_full, a new accept needs it clear: never both in one cycle.
        if (frame_end && pend_full) begin
            disp_dat_nxt  = pend_dat;
            disp_lz_nxt   = pend_lz;
            pend_full_nxt = 1'b0;
        end
        if (load.load_valid && !pend_full) begin
            pend_dat_nxt  = load.load_data;
            pend_lz_nxt   = load.blank_lz;
            pend_full_nxt = 1'b1;
        end

        // zero_above[k] is set when nibbles k..NUM_DIGITS-1 of the display are all zero.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_run        = lz_run & (disp_dat_nxt[4*k +: 4] == 4'h0);
            zero_above[k] = lz_run;
        end
        suppress = disp_lz_nxt && (idx_nxt != '0) && zero_above[idx_nxt];

        if (state_nxt == SCAN && !suppress) begin
            digit_sel_nxt[idx_nxt] = 1'b0;
            blank_nxt              = 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (IW'(k) == idx_nxt) begin
                    nibble_nxt = disp_dat_nxt[4*k +: 4];
                end
            end
        end
    end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Randomized and directed bench for sevseg_scan_ctrl against a frame-arithmetic reference model.
module tb_sevseg_scan_ctrl;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int GC = 1;
    localparam int SL = GC + DW;
    localparam int FP = N * SL;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   nibble;
    logic [N-1:0] digit_sel;
    logic         blank;
    logic         frame_done;

    always #5 clk = ~clk;

    sevseg_scan_ctrl_if #(.NUM_DIGITS(N)) lif ();

    sevseg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DW),
        .GAP_CYCLES  (GC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (lif.slave),
        .nibble    (nibble),
        .digit_sel (digit_sel),
        .blank     (blank),
        .frame_done(frame_done)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: t is the cycle number counted from the first cycle after reset (t=1).
    int          t = 0;
    logic [15:0] m_disp = '0;
    logic        m_dlz = 1'b0;
    logic [15:0] m_pend = '0;
    logic        m_plz = 1'b0;
    logic        m_full = 1'b0;
    logic        last_acc = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    task automatic check_outputs();
        int          p;
        int          d;
        int          ph;
        logic [15:0] above;
        logic        lit;
        logic [N-1:0] exp_sel;
        if (t == 0) return;
        p     = (t - 1) % FP;
        d     = p / SL;
        ph    = p % SL;
        above = m_disp >> (4 * d);
        lit   = (ph >= GC) && !(m_dlz && d != 0 && above == 16'h0);
        exp_sel = '1;
        if (lit) exp_sel[d] = 1'b0;
        check_eq("digit_sel", 32'(digit_sel), 32'(exp_sel));
        check_eq("blank", 32'(blank), 32'(!lit));
        check_eq("frame_done", 32'(frame_done), 32'(t > 1 && p == 0));
        check_eq("load_ready", 32'(lif.load_ready), 32'(!m_full));
        if (lit) check_eq("nibble", 32'(nibble), 32'(above[3:0]));
        if (t == 1) check_eq("nibble_reset", 32'(nibble), 32'd0);
    endtask

    task automatic model_edge();
        logic acc;
        if (reset) begin
            t        = 1;
            m_disp   = '0;
            m_dlz    = 1'b0;
            m_full   = 1'b0;
            last_acc = 1'b0;
        end else begin
            acc = lif.load_valid && !m_full;
            if (t > 0 && t % FP == 0 && m_full) begin
                m_disp = m_pend;
                m_dlz  = m_plz;
                m_full = 1'b0;
            end
            if (acc) begin
                m_pend = lif.load_data;
                m_plz  = lif.blank_lz;
                m_full = 1'b1;
            end
            last_acc = acc;
            if (t > 0) t++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic lz);
        lif.load_valid = 1'b1;
        lif.load_data  = d;
        lif.blank_lz   = lz;
        for (int i = 0; i < 3 * FP; i++) begin
            step();
            if (last_acc) break;
        end
        check_eq("load_accept", 32'(last_acc), 32'd1);
        lif.load_valid = 1'b0;
    endtask

    task automatic wait_frame_last();
        for (int i = 0; i < FP && (t % FP) != 0; i++) step();
    endtask

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        lif.blank_lz   = 1'b0;
        reset = 1'b1;
        run(2);
        reset = 1'b0;

        // Idle frame, then a load arriving in cycle 3.
        for (int i = 0; i < 10 && t < 3; i++) step();
        do_load(16'hA3F0, 1'b0);
        run(2 * FP + 5);

        // Back-to-back loads with valid held across the stall.
        do_load(16'h1111, 1'b0);
        do_load(16'h2222, 1'b0);
        run(2 * FP);

        // Leading-zero blanking.
        do_load(16'h0050, 1'b1);
        run(2 * FP);
        do_load(16'h0000, 1'b1);
        run(2 * FP);

        // Handshake in the exact frame-end cycle with pending empty.
        wait_frame_last();
        check_eq("fe_pend_empty", 32'(lif.load_ready), 32'd1);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h7E00;
        lif.blank_lz   = 1'b0;
        step();
        check_eq("fe_accept", 32'(last_acc), 32'd1);
        lif.load_valid = 1'b0;
        run(3 * FP);

        // Reset while digit 2 is lit and a load is pending.
        wait_frame_last();
        step();
        do_load(16'hBEEF, 1'b0);
        for (int i = 0; i < FP && !(((t - 1) % FP) / SL == 2 && ((t - 1) % SL) >= GC); i++) step();
        check_eq("pre_rst_digit2", 32'(digit_sel), 32'(4'b1011));
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(3 * FP);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!lif.load_valid || last_acc) begin
                lif.load_valid = ($urandom_range(0, 3) == 0);
                lif.load_data  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
                lif.blank_lz   = 1'($urandom_range(0, 1));
            end
            step();
        end
        reset = 1'b0;
        lif.load_valid = 1'b0;
        run(2 * FP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
